fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of `async_fifo` among `NREQ` producers in the write-clock domain. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives `winc`/`wdata` directly into the FIFO. It honours `wfull` beat-by-beat and shortens bursts when `almost_full` is asserted.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter that must be able to hold m.
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping modulo NREQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            found,
  output logic [IW-1:0]   index
);

  int cand;

  // Wrap by compare-and-subtract so non-power-of-two NREQ stays in range.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NREQ producers,
// granting bounded bursts and honouring wfull beat by beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = idx_width(NREQ),
  localparam int BW        = cnt_width(MAX_BURST)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  almost_full,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  burst_done
);

  arb_state_t       state, next_state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    pick_index;
  logic             pick_found;
  logic [BW-1:0]    beat_cnt;
  logic [BW-1:0]    limit;
  logic [BW-1:0]    lim_m1;
  logic             start;
  logic             beat;
  logic             burst_end;
  logic             cur_valid;
  logic [DSIZE-1:0] req_bytes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DSIZE +: DSIZE];
  end

  assign lim_m1 = limit - BW'(1);

  fifo_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_index)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= next_state;
  end

  // Outputs are purely combinational so a reset mid-burst drops them at once.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    beat       = 1'b0;
    burst_end  = 1'b0;
    cur_valid  = 1'b0;
    req_ready  = '0;
    winc       = 1'b0;
    wdata      = '0;
    busy       = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !wfull) begin
          start      = 1'b1;
          next_state = GRANT;
        end
      end
      GRANT: begin
        busy                = 1'b1;
        cur_valid           = req_valid[grant_id];
        beat                = cur_valid && !wfull;
        winc                = beat;
        req_ready[grant_id] = beat;
        wdata               = req_bytes[grant_id];
        if (!cur_valid || (beat && beat_cnt == lim_m1)) begin
          burst_end  = 1'b1;
          burst_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // almost_full is only looked at when the grant is made.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      limit      <= BW'(MAX_BURST);
      beat_cnt   <= '0;
    end else if (start) begin
      grant_id   <= pick_index;
      last_grant <= pick_index;
      limit      <= almost_full ? BW'(1) : BW'(MAX_BURST);
      beat_cnt   <= '0;
    end else if (burst_end) begin
      beat_cnt <= '0;
    end else if (beat && beat_cnt != lim_m1) begin
      beat_cnt <= beat_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed and random producer traffic checked against a
// burst-level reference model of the arbiter.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  almost_full;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  burst_done;

  int passed = 0;
  int failed = 0;
  int checks = 0;
  int m_owner, m_left, m_last, m_gid;
  int seq [NREQ];
  int done_seen, beats_seen;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wfull       (wfull),
    .almost_full (almost_full),
    .winc        (winc),
    .wdata       (wdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_done  (burst_done)
  );

  always #5 wclk = ~wclk;

  function automatic logic [7:0] byte_of(input int i);
    return 8'((i << 4) | (seq[i] & 15));
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_last  = NREQ - 1;
    m_gid   = 0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model (owner + beats remaining) across the rising edge.
  task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic full, input logic af);
    logic [NREQ-1:0] e_ready;
    logic            e_winc, e_busy, e_done;
    logic [7:0]      e_wdata;
    int              o;
    req_valid   = v;
    wfull       = full;
    almost_full = af;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = byte_of(i);
    @(negedge wclk);
    e_ready = '0;
    e_winc  = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_wdata = '0;
    o       = 0;
    if (m_owner >= 0) begin
      o       = m_owner;
      e_busy  = 1'b1;
      e_wdata = byte_of(o);
      e_winc  = v[o] && !full;
      if (e_winc) e_ready[o] = 1'b1;
      e_done  = !v[o] || (e_winc && m_left == 1);
    end
    check_output("winc",       32'(winc),       32'(e_winc));
    check_output("req_ready",  32'(req_ready),  32'(e_ready));
    check_output("wdata",      32'(wdata),      32'(e_wdata));
    check_output("busy",       32'(busy),       32'(e_busy));
    check_output("burst_done", 32'(burst_done), 32'(e_done));
    check_output("grant_id",   32'(grant_id),   32'(m_gid));
    if (burst_done === 1'b1) done_seen++;
    if (winc === 1'b1) beats_seen++;
    if (m_owner >= 0) begin
      if (e_winc) begin
        seq[o]++;
        m_left--;
      end
      if (e_done) m_owner = -1;
    end else if (v != '0 && !full) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && v[c]) m_owner = c;
      end
      m_last = m_owner;
      m_gid  = m_owner;
      m_left = af ? 1 : MAX_BURST;
    end
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n      = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    wfull       = 1'b0;
    almost_full = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    model_reset();
    done_seen  = 0;
    beats_seen = 0;

    repeat (2) @(negedge wclk);
    check_output("rst_winc",       32'(winc),       32'd0);
    check_output("rst_req_ready",  32'(req_ready),  32'd0);
    check_output("rst_wdata",      32'(wdata),      32'd0);
    check_output("rst_busy",       32'(busy),       32'd0);
    check_output("rst_burst_done", 32'(burst_done), 32'd0);
    check_output("rst_grant_id",   32'(grant_id),   32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    $display("[TB] single producer 1, two full bursts");
    for (int n = 0; n < 10; n++) apply_stimulus(4'b0010, 1'b0, 1'b0);
    check_output("p1_burst_done_count", 32'(done_seen),  32'd2);
    check_output("p1_beat_count",       32'(beats_seen), 32'd8);
    check_output("p1_bytes_sent",       32'(seq[1]),     32'd8);

    $display("[TB] all producers valid");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    done_seen  = 0;
    beats_seen = 0;
    for (int n = 0; n < 25; n++) apply_stimulus(4'b1111, 1'b0, 1'b0);
    check_output("all_burst_done_count", 32'(done_seen),  32'd5);
    check_output("all_beat_count",       32'(beats_seen), 32'd20);

    $display("[TB] producer 2 drops valid mid-burst");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    apply_stimulus(4'b0100, 1'b0, 1'b0);
    apply_stimulus(4'b0100, 1'b0, 1'b0);
    apply_stimulus(4'b0100, 1'b0, 1'b0);
    apply_stimulus(4'b1000, 1'b0, 1'b0);
    apply_stimulus(4'b1100, 1'b0, 1'b0);
    check_output("drop_next_grant", 32'(grant_id), 32'd3);

    $display("[TB] wfull stall mid-burst");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    done_seen  = 0;
    beats_seen = 0;
    for (int n = 0; n < 3; n++) apply_stimulus(4'b1111, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) apply_stimulus(4'b1111, 1'b1, 1'b0);
    check_output("stall_beats_before_resume", 32'(beats_seen), 32'd2);
    for (int n = 0; n < 2; n++) apply_stimulus(4'b1111, 1'b0, 1'b0);
    check_output("stall_beat_count", 32'(beats_seen), 32'd4);
    check_output("stall_done_count", 32'(done_seen),  32'd1);

    $display("[TB] almost_full limits bursts to one beat");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    done_seen  = 0;
    beats_seen = 0;
    for (int n = 0; n < 8; n++) apply_stimulus(4'b1111, 1'b0, 1'b1);
    check_output("af_beat_count", 32'(beats_seen), 32'd4);
    check_output("af_done_count", 32'(done_seen),  32'd4);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0] v;
      for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 3) != 0);
      apply_stimulus(v, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] reset mid-burst");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    apply_stimulus(4'b1111, 1'b0, 1'b0);
    apply_stimulus(4'b1111, 1'b0, 1'b0);
    wrst_n = 1'b0;
    #1;
    check_output("midrst_winc",       32'(winc),       32'd0);
    check_output("midrst_req_ready",  32'(req_ready),  32'd0);
    check_output("midrst_busy",       32'(busy),       32'd0);
    check_output("midrst_burst_done", 32'(burst_done), 32'd0);
    check_output("midrst_grant_id",   32'(grant_id),   32'd0);
    model_reset();
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    for (int n = 0; n < 12; n++) apply_stimulus(4'b1111, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
